trap_sequencer: RTL and testbench

Upstream sequencer for the privilege system. It watches the writeback stage for exceptions, `mret`/`sret` and pending machine interrupts, and picks one event. It kills the retiring instruction, drains outstanding memory traffic and flushes the pipeline. It then issues exactly one single-cycle trap or xRET request (`trap_en`/`trap_is_ret` plus cause, pc and tval) to the privilege system.

---
 rtl/trap_sequencer_pkg.sv | 44 ++++
 rtl/trap_sequencer_if.sv | 54 +++++
 rtl/trap_sequencer_irq_select.sv | 55 +++++
 rtl/trap_sequencer.sv | 175 +++++++++++++++++
 tb/tb_trap_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// trap_sequencer_pkg
// Shared definitions for the trap sequencer and its users:
//   - privilege levels (PRIV_U/S/M)
//   - synchronous exception codes (EXC_*)
//   - machine interrupt codes (IRQ_MSI/MTI/MEI)
//   - the sequencer state enum and the debug struct exported by the top
// -----------------------------------------------------------------------------
package trap_sequencer_pkg;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam logic [5:0] EXC_INSTR_MISALIGNED   = 6'd0;
  localparam logic [5:0] EXC_INSTR_ACCESS_FAULT = 6'd1;
  localparam logic [5:0] EXC_ILLEGAL_INSTR      = 6'd2;
  localparam logic [5:0] EXC_BREAKPOINT         = 6'd3;
  localparam logic [5:0] EXC_LOAD_MISALIGNED    = 6'd4;
  localparam logic [5:0] EXC_LOAD_ACCESS_FAULT  = 6'd5;
  localparam logic [5:0] EXC_STORE_MISALIGNED   = 6'd6;
  localparam logic [5:0] EXC_STORE_ACCESS_FAULT = 6'd7;
  localparam logic [5:0] EXC_ECALL_U            = 6'd8;
  localparam logic [5:0] EXC_ECALL_S            = 6'd9;
  localparam logic [5:0] EXC_ECALL_M            = 6'd11;

  localparam logic [5:0] IRQ_MSI = 6'd3;
  localparam logic [5:0] IRQ_MTI = 6'd7;
  localparam logic [5:0] IRQ_MEI = 6'd11;

  typedef enum logic [1:0] {
    TS_IDLE  = 2'd0,
    TS_DRAIN = 2'd1,
    TS_FIRE  = 2'd2,
    TS_FLUSH = 2'd3
  } trap_seq_state_t;

  // drain_timeout pulses in the DRAIN cycle that gives up on mem_busy.
  typedef struct packed {
    trap_seq_state_t state;
    logic            drain_timeout;
  } trap_seq_dbg_t;

endpackage

// File: rtl/trap_sequencer_if.sv
// -----------------------------------------------------------------------------
// trap_sequencer_if
// Bundles the writeback/interrupt inputs and the trap request outputs of the
// trap sequencer.
//   master : pipeline / privilege-system side (drives wb_*, irq_*, CSR state)
//   slave  : the sequencer itself
//
// Handshake: trap_en and trap_is_ret are single-cycle valid pulses with no
// ready (the privilege system must accept them); at most one is high in any
// cycle, and trap_cause/trap_pc/trap_mtval/trap_ret_from_priv are valid in
// exactly that cycle. wb_kill is a combinational qualifier on the current
// wb_valid beat; flush is a level.
// -----------------------------------------------------------------------------
interface trap_sequencer_if #(
  parameter int REG_WIDTH = 64
);
  logic                 wb_valid;
  logic [REG_WIDTH-1:0] wb_pc;
  logic                 wb_exc;
  logic [5:0]           wb_exc_code;
  logic [REG_WIDTH-1:0] wb_tval;
  logic                 wb_is_mret;
  logic                 wb_is_sret;
  logic                 irq_msip;
  logic                 irq_mtip;
  logic                 irq_meip;
  logic [REG_WIDTH-1:0] mie_csr;
  logic                 mstatus_mie;
  logic [1:0]           curr_priv_mode;
  logic                 mem_busy;

  logic                 wb_kill;
  logic                 flush;
  logic                 trap_en;
  logic [REG_WIDTH-1:0] trap_cause;
  logic [REG_WIDTH-1:0] trap_pc;
  logic [REG_WIDTH-1:0] trap_mtval;
  logic                 trap_is_ret;
  logic [1:0]           trap_ret_from_priv;

  modport master (
    output wb_valid, wb_pc, wb_exc, wb_exc_code, wb_tval, wb_is_mret, wb_is_sret,
    output irq_msip, irq_mtip, irq_meip, mie_csr, mstatus_mie, curr_priv_mode, mem_busy,
    input  wb_kill, flush, trap_en, trap_cause, trap_pc, trap_mtval,
    input  trap_is_ret, trap_ret_from_priv
  );

  modport slave (
    input  wb_valid, wb_pc, wb_exc, wb_exc_code, wb_tval, wb_is_mret, wb_is_sret,
    input  irq_msip, irq_mtip, irq_meip, mie_csr, mstatus_mie, curr_priv_mode, mem_busy,
    output wb_kill, flush, trap_en, trap_cause, trap_pc, trap_mtval,
    output trap_is_ret, trap_ret_from_priv
  );
endinterface

// File: rtl/trap_sequencer_irq_select.sv
// -----------------------------------------------------------------------------
// irq_select
// Combinational machine-interrupt qualification and priority encode.
//   msip_i/mtip_i/meip_i : pending interrupt levels
//   mie_i                : mie CSR (only bits 3, 7, 11 matter)
//   mstatus_mie_i        : global machine interrupt enable
//   priv_i               : current privilege mode
//   irq_take_o           : an enabled interrupt is pending
//   irq_code_o           : its code, priority MEI > MSI > MTI (0 when none)
// -----------------------------------------------------------------------------
module irq_select
  import trap_sequencer_pkg::*;
#(
  parameter int REG_WIDTH = 64
) (
  input  logic                 msip_i,
  input  logic                 mtip_i,
  input  logic                 meip_i,
  input  logic [REG_WIDTH-1:0] mie_i,
  input  logic                 mstatus_mie_i,
  input  logic [1:0]           priv_i,
  output logic                 irq_take_o,
  output logic [5:0]           irq_code_o
);

  logic glob_en;
  logic mei_en;
  logic msi_en;
  logic mti_en;
  logic unused_mie;

  // Below M-mode machine interrupts are always globally enabled.
  assign glob_en = (priv_i != PRIV_M) || mstatus_mie_i;
  assign mei_en  = meip_i && mie_i[IRQ_MEI] && glob_en;
  assign msi_en  = msip_i && mie_i[IRQ_MSI] && glob_en;
  assign mti_en  = mtip_i && mie_i[IRQ_MTI] && glob_en;

  assign unused_mie = ^mie_i;

  always_comb begin
    irq_take_o = 1'b0;
    irq_code_o = 6'd0;
    if (mei_en) begin
      irq_take_o = 1'b1;
      irq_code_o = IRQ_MEI;
    end else if (msi_en) begin
      irq_take_o = 1'b1;
      irq_code_o = IRQ_MSI;
    end else if (mti_en) begin
      irq_take_o = 1'b1;
      irq_code_o = IRQ_MTI;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// -----------------------------------------------------------------------------
// trap_sequencer
// Watches writeback for interrupts, exceptions and xRETs, kills the retiring
// instruction, drains memory traffic, then issues one single-cycle trap or
// xRET request to the privilege system, followed by a fixed flush tail.
//   clk, reset : clock, synchronous active-high reset
//   bus        : trap_sequencer_if.slave (writeback inputs, trap outputs)
//   dbg_o      : current FSM state and drain-timeout pulse
// Sequence for an event seen at cycle N: wb_kill at N, DRAIN from N+1,
// FIRE once mem_busy is low (or the timeout hits), then FLUSH_CYCLES of FLUSH.
// -----------------------------------------------------------------------------
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int REG_WIDTH     = 64,
  parameter int FLUSH_CYCLES  = 2,
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  trap_sequencer_if.slave   bus,
  output trap_seq_dbg_t     dbg_o
);

  localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  trap_seq_state_t      state_q, state_d;
  logic [DCW-1:0]       drain_cnt_q, drain_cnt_d;
  logic [FCW-1:0]       flush_cnt_q, flush_cnt_d;
  logic [REG_WIDTH-1:0] cause_q, cause_d;
  logic [REG_WIDTH-1:0] pc_q, pc_d;
  logic [REG_WIDTH-1:0] tval_q, tval_d;
  logic                 is_ret_q, is_ret_d;
  logic [1:0]           ret_priv_q, ret_priv_d;

  logic                 irq_take;
  logic [5:0]           irq_code;
  logic [REG_WIDTH-1:0] irq_cause;
  logic                 wb_kill;
  logic                 drain_timeout;

  irq_select #(.REG_WIDTH(REG_WIDTH)) u_irq_select (
    .msip_i        (bus.irq_msip),
    .mtip_i        (bus.irq_mtip),
    .meip_i        (bus.irq_meip),
    .mie_i         (bus.mie_csr),
    .mstatus_mie_i (bus.mstatus_mie),
    .priv_i        (bus.curr_priv_mode),
    .irq_take_o    (irq_take),
    .irq_code_o    (irq_code)
  );

  always_comb begin
    irq_cause                = '0;
    irq_cause[REG_WIDTH-1]   = 1'b1;
    irq_cause[5:0]           = irq_code;
  end

  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    cause_d       = cause_q;
    pc_d          = pc_q;
    tval_d        = tval_q;
    is_ret_d      = is_ret_q;
    ret_priv_d    = ret_priv_q;
    wb_kill       = 1'b0;
    drain_timeout = 1'b0;

    case (state_q)
      TS_IDLE: begin
        if (bus.wb_valid && (irq_take || bus.wb_exc || bus.wb_is_mret || bus.wb_is_sret)) begin
          wb_kill     = 1'b1;
          state_d     = TS_DRAIN;
          drain_cnt_d = '0;
          pc_d        = bus.wb_pc;
          cause_d     = '0;
          tval_d      = '0;
          is_ret_d    = 1'b0;
          ret_priv_d  = PRIV_U;
          if (irq_take) begin
            cause_d = irq_cause;
          end else if (bus.wb_exc) begin
            cause_d = REG_WIDTH'(bus.wb_exc_code);
            tval_d  = bus.wb_tval;
          end else if (bus.wb_is_mret) begin
            if (bus.curr_priv_mode != PRIV_M) begin
              cause_d = REG_WIDTH'(EXC_ILLEGAL_INSTR);
            end else begin
              is_ret_d   = 1'b1;
              ret_priv_d = PRIV_M;
            end
          end else begin
            // sret: legal from S and M, illegal from U.
            if (bus.curr_priv_mode == PRIV_U) begin
              cause_d = REG_WIDTH'(EXC_ILLEGAL_INSTR);
            end else begin
              is_ret_d   = 1'b1;
              ret_priv_d = PRIV_S;
            end
          end
        end
      end

      TS_DRAIN: begin
        wb_kill = bus.wb_valid;
        if (!bus.mem_busy) begin
          state_d = TS_FIRE;
        end else if (drain_cnt_q == DCW'(DRAIN_TIMEOUT - 1)) begin
          // Memory never went idle; proceed rather than deadlock the core.
          drain_timeout = 1'b1;
          state_d       = TS_FIRE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end

      TS_FIRE: begin
        wb_kill     = bus.wb_valid;
        flush_cnt_d = FCW'(FLUSH_CYCLES - 1);
        state_d     = TS_FLUSH;
      end

      TS_FLUSH: begin
        wb_kill = bus.wb_valid;
        if (flush_cnt_q == '0) begin
          state_d = TS_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = TS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= TS_IDLE;
      drain_cnt_q <= '0;
      flush_cnt_q <= '0;
      cause_q     <= '0;
      pc_q        <= '0;
      tval_q      <= '0;
      is_ret_q    <= 1'b0;
      ret_priv_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      cause_q     <= cause_d;
      pc_q        <= pc_d;
      tval_q      <= tval_d;
      is_ret_q    <= is_ret_d;
      ret_priv_q  <= ret_priv_d;
    end
  end

  assign bus.wb_kill            = wb_kill;
  assign bus.flush              = (state_q != TS_IDLE);
  assign bus.trap_en            = (state_q == TS_FIRE) && !is_ret_q;
  assign bus.trap_is_ret        = (state_q == TS_FIRE) && is_ret_q;
  assign bus.trap_cause         = cause_q;
  assign bus.trap_pc            = pc_q;
  assign bus.trap_mtval         = tval_q;
  assign bus.trap_ret_from_priv = ret_priv_q;

  assign dbg_o.state         = state_q;
  assign dbg_o.drain_timeout = drain_timeout;

endmodule

// File: tb/tb_trap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_trap_sequencer
// Directed bench for trap_sequencer. Each event pushes its expected request
// (fire cycle, kind, payload) into exp_q; a monitor pops and compares on every
// trap_en / trap_is_ret pulse. Per-cycle wb_kill / flush checks are made by
// the driver task.
// -----------------------------------------------------------------------------
module tb_trap_sequencer;
  import trap_sequencer_pkg::*;

  localparam int FC = 2;
  localparam int W  = 227;  // {fire_cycle[31:0], is_ret, ret_priv[1:0], cause, pc, tval}

  logic          clk;
  logic          reset;
  trap_seq_dbg_t dbg;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  mon_e;

  trap_sequencer_if #(.REG_WIDTH(64)) bus ();

  trap_sequencer #(
    .REG_WIDTH     (64),
    .FLUSH_CYCLES  (FC),
    .DRAIN_TIMEOUT (255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .dbg_o (dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_wb();
    bus.wb_valid    = 1'b0;
    bus.wb_pc       = '0;
    bus.wb_exc      = 1'b0;
    bus.wb_exc_code = '0;
    bus.wb_tval     = '0;
    bus.wb_is_mret  = 1'b0;
    bus.wb_is_sret  = 1'b0;
  endtask

  task automatic set_wb(input logic [63:0] pc, input logic exc, input logic [5:0] code,
                        input logic [63:0] tval, input logic mret, input logic sret);
    bus.wb_pc       = pc;
    bus.wb_exc      = exc;
    bus.wb_exc_code = code;
    bus.wb_tval     = tval;
    bus.wb_is_mret  = mret;
    bus.wb_is_sret  = sret;
  endtask

  // Entered just after a posedge with wb fields already set. Presents one
  // wb_valid beat at cycle n and follows the sequence back to IDLE.
  task automatic do_event(input logic take, input logic is_ret, input logic [1:0] rp,
                          input logic [63:0] cause, input logic [63:0] tval,
                          input int fire_off, input int busy_until);
    int          n;
    int          last;
    logic [63:0] pc_saved;
    n        = cyc;
    pc_saved = bus.wb_pc;
    if (take) exp_q.push_back({32'(n + fire_off), is_ret, rp, cause, pc_saved, tval});
    bus.wb_valid = 1'b1;
    @(negedge clk);
    chk("wb_kill", 64'(bus.wb_kill), 64'(take));
    last = take ? fire_off + FC + 1 : 1;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      if (k == 1) clear_wb();
      bus.mem_busy = (k <= busy_until);
      @(negedge clk);
      chk("flush", 64'(bus.flush), 64'(take && (k <= fire_off + FC)));
      if (take && k == 1) chk("trap_pc_latched", bus.trap_pc, pc_saved);
    end
    bus.mem_busy = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (bus.trap_en || bus.trap_is_ret) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 64'({bus.trap_en, bus.trap_is_ret}), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("fire_cycle", 64'(cyc), 64'(mon_e[226:195]));
        chk("trap_en", 64'(bus.trap_en), 64'(!mon_e[194]));
        chk("trap_is_ret", 64'(bus.trap_is_ret), 64'(mon_e[194]));
        chk("trap_pc", bus.trap_pc, mon_e[127:64]);
        if (mon_e[194]) begin
          chk("ret_from_priv", 64'(bus.trap_ret_from_priv), 64'(mon_e[193:192]));
        end else begin
          chk("trap_cause", bus.trap_cause, mon_e[191:128]);
          chk("trap_mtval", bus.trap_mtval, mon_e[63:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b1;
    clear_wb();
    bus.irq_msip       = 1'b0;
    bus.irq_mtip       = 1'b0;
    bus.irq_meip       = 1'b0;
    bus.mie_csr        = '0;
    bus.mstatus_mie    = 1'b0;
    bus.curr_priv_mode = PRIV_M;
    bus.mem_busy       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flush", 64'(bus.flush), 64'd0);
    chk("rst_trap_en", 64'(bus.trap_en), 64'd0);
    chk("rst_trap_is_ret", 64'(bus.trap_is_ret), 64'd0);
    chk("rst_cause", bus.trap_cause, 64'd0);
    chk("rst_pc", bus.trap_pc, 64'd0);
    chk("rst_tval", bus.trap_mtval, 64'd0);
    chk("rst_ret_priv", 64'(bus.trap_ret_from_priv), 64'd0);
    chk("rst_state", 64'(dbg.state), 64'(TS_IDLE));
    @(posedge clk); #1;
    reset = 1'b0;

    // Plain exception: FIRE at N+2, flush low at N+5.
    set_wb(64'h8000_0100, 1'b1, 6'd5, 64'h1234, 1'b0, 1'b0);
    do_event(1'b1, 1'b0, 2'd0, 64'd5, 64'h1234, 2, 0);

    // MEI + MTI pending with an exception: MEI wins, tval 0.
    bus.mstatus_mie = 1'b1;
    bus.mie_csr     = 64'h888;
    bus.irq_mtip    = 1'b1;
    bus.irq_meip    = 1'b1;
    set_wb(64'h8000_0200, 1'b1, 6'd2, 64'h55, 1'b0, 1'b0);
    do_event(1'b1, 1'b0, 2'd0, 64'h8000_0000_0000_000B, 64'd0, 2, 0);

    // MSI outranks MTI.
    bus.irq_meip = 1'b0;
    bus.irq_msip = 1'b1;
    set_wb(64'h8000_0204, 1'b0, 6'd0, 64'h0, 1'b0, 1'b0);
    do_event(1'b1, 1'b0, 2'd0, 64'h8000_0000_0000_0003, 64'd0, 2, 0);

    // MTI in M-mode with mstatus.MIE=0: nothing taken.
    bus.irq_msip    = 1'b0;
    bus.mstatus_mie = 1'b0;
    set_wb(64'h8000_0208, 1'b0, 6'd0, 64'h0, 1'b0, 1'b0);
    do_event(1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 2, 0);

    // Enabled interrupt but no retiring instruction: no detection.
    bus.curr_priv_mode = PRIV_S;
    repeat (2) begin
      @(negedge clk);
      chk("idle_no_kill", 64'(bus.wb_kill), 64'd0);
      chk("idle_no_flush", 64'(bus.flush), 64'd0);
      @(posedge clk); #1;
    end

    // Same MTI from S-mode: taken.
    set_wb(64'h8000_0300, 1'b0, 6'd0, 64'h0, 1'b0, 1'b0);
    do_event(1'b1, 1'b0, 2'd0, 64'h8000_0000_0000_0007, 64'd0, 2, 0);
    bus.irq_mtip = 1'b0;
    bus.mie_csr  = '0;

    // Legal mret from M, legal sret from S.
    bus.curr_priv_mode = PRIV_M;
    set_wb(64'h8000_0400, 1'b0, 6'd0, 64'h0, 1'b1, 1'b0);
    do_event(1'b1, 1'b1, PRIV_M, 64'd0, 64'd0, 2, 0);
    bus.curr_priv_mode = PRIV_S;
    set_wb(64'h8000_0404, 1'b0, 6'd0, 64'h0, 1'b0, 1'b1);
    do_event(1'b1, 1'b1, PRIV_S, 64'd0, 64'd0, 2, 0);

    // Illegal xRETs: mret from S, sret from U.
    set_wb(64'h8000_0408, 1'b0, 6'd0, 64'h77, 1'b1, 1'b0);
    do_event(1'b1, 1'b0, 2'd0, 64'd2, 64'd0, 2, 0);
    bus.curr_priv_mode = PRIV_U;
    set_wb(64'h8000_0500, 1'b0, 6'd0, 64'h0, 1'b0, 1'b1);
    do_event(1'b1, 1'b0, 2'd0, 64'd2, 64'd0, 2, 0);

    // Exception and mret together: exception wins.
    bus.curr_priv_mode = PRIV_M;
    set_wb(64'h8000_0600, 1'b1, 6'd4, 64'hDEAD, 1'b1, 1'b0);
    do_event(1'b1, 1'b0, 2'd0, 64'd4, 64'hDEAD, 2, 0);

    // mem_busy high for 10 DRAIN cycles: FIRE the cycle after it falls.
    set_wb(64'h8000_0700, 1'b1, 6'd7, 64'h70, 1'b0, 1'b0);
    do_event(1'b1, 1'b0, 2'd0, 64'd7, 64'h70, 12, 10);

    // mem_busy stuck: FIRE after 255 DRAIN cycles.
    set_wb(64'h8000_0800, 1'b1, 6'd13, 64'hBAD, 1'b0, 1'b0);
    do_event(1'b1, 1'b0, 2'd0, 64'd13, 64'hBAD, 256, 100000);

    // Reset while in DRAIN: no request, outputs cleared, then normal service.
    set_wb(64'h8000_0880, 1'b1, 6'd6, 64'h66, 1'b0, 1'b0);
    n = cyc;
    bus.wb_valid = 1'b1;
    @(negedge clk);
    chk("rst_drain_kill", 64'(bus.wb_kill), 64'd1);
    @(posedge clk); #1;
    clear_wb();
    bus.mem_busy = 1'b1;
    @(negedge clk);
    chk("rst_drain_in_drain", 64'(dbg.state), 64'(TS_DRAIN));
    reset = 1'b1;
    @(posedge clk); #1;
    reset        = 1'b0;
    bus.mem_busy = 1'b0;
    @(negedge clk);
    chk("rst_drain_flush", 64'(bus.flush), 64'd0);
    chk("rst_drain_cause", bus.trap_cause, 64'd0);
    chk("rst_drain_pc", bus.trap_pc, 64'd0);
    chk("rst_drain_tval", bus.trap_mtval, 64'd0);
    chk("rst_drain_state", 64'(dbg.state), 64'(TS_IDLE));
    chk("rst_drain_cycle", 64'(cyc), 64'(n + 2));
    repeat (4) begin
      @(posedge clk); #1;
    end
    set_wb(64'h8000_0900, 1'b1, 6'd1, 64'h9, 1'b0, 1'b0);
    do_event(1'b1, 1'b0, 2'd0, 64'd1, 64'h9, 2, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
